// File: rtl/count_arb.sv
// Round-robin owner arbitration for a shared up counter.
// Clears the counter, runs it to the owner's latched limit, then pulses done.
module count_arb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] limit0,
  input  logic [WIDTH-1:0] limit1,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_owner;
  logic             w_owner_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic [WIDTH-1:0] r_limit_q;
  logic [WIDTH-1:0] w_limit_nxt;
  logic             w_pick;
  logic             w_own_req;
  logic             w_at_limit;
  logic [1:0]       w_owner_oh;

  // With both requesting, favour whoever was not served last
  assign w_pick     = (req == 2'b11) ? ~r_last : req[1];
  assign w_own_req  = req[r_owner];
  assign w_at_limit = (cnt_val == r_limit_q);
  assign w_owner_oh = r_owner ? 2'b10 : 2'b01;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_limit_q <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_last    <= w_last_nxt;
      r_limit_q <= w_limit_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_limit_nxt = r_limit_q;
    cnt_en      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_owner_nxt = w_pick;
          w_limit_nxt = w_pick ? limit1 : limit0;
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (!w_own_req) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_owner;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // Dropping the request aborts before any further count
        if (!w_own_req) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_owner;
        end else begin
          cnt_en = ~w_at_limit;
          if (w_at_limit) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_last_nxt  = r_owner;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy    = (r_state != S_IDLE);
  assign gnt     = busy ? w_owner_oh : 2'b00;
  assign done    = (r_state == S_DONE) ? w_owner_oh : 2'b00;
  assign cnt_clr = (r_state == S_CLEAR);

endmodule

// File: tb/tb_count_arb.sv
// Bench for count_arb: directed scenarios then random traffic, checked against
// a timeline model that expands each grant into its expected phase sequence.
module tb_count_arb;

  localparam int unsigned W = 4;

  logic         clk    = 1'b0;
  logic         reset  = 1'b1;
  logic [1:0]   req    = 2'b00;
  logic [W-1:0] limit0 = '0;
  logic [W-1:0] limit1 = '0;
  logic [W-1:0] cnt_val = '0;
  logic         cnt_clr;
  logic         cnt_en;
  logic [1:0]   gnt;
  logic [1:0]   done;
  logic         busy;

  count_arb #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .limit0(limit0), .limit1(limit1),
    .cnt_val(cnt_val), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .gnt(gnt),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared counter that the arbiter drives
  always @(posedge clk) begin
    if (cnt_clr)     cnt_val <= '0;
    else if (cnt_en) cnt_val <= cnt_val + W'(1);
  end

  // Pending phases of the current grant: 0 clear, 1 counting run, 2 run at limit, 3 done
  int   plan[$];
  bit   m_owner;
  bit   m_last;
  int   m_limit;
  int   errors = 0;
  int   checks = 0;
  int   n_done = 0;
  logic [1:0] done_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [6:0] exp_v;
    logic [6:0] obs_v;
    logic [1:0] oh;
    @(negedge clk);
    oh = m_owner ? 2'b10 : 2'b01;
    if (plan.size() == 0) exp_v = '0;
    else exp_v = {oh, (plan[0] == 3) ? oh : 2'b00, 1'b1, plan[0] == 0,
                  (plan[0] == 1) && req[m_owner]};
    obs_v = {gnt, done, busy, cnt_clr, cnt_en};
    check("gnt_done_busy_clr_en", 32'(obs_v), 32'(exp_v));
    if (plan.size() != 0 && plan[0] == 3)
      check("cnt_val_at_done", 32'(cnt_val), 32'(m_limit));
    if (done != 2'b00) begin
      n_done++;
      done_q.push_back(done);
    end
    // What the coming edge does
    if (reset) begin
      plan.delete();
      m_last = 1'b1;
    end else if (plan.size() == 0) begin
      if (req != 2'b00) begin
        m_owner = (req == 2'b11) ? !m_last : req[1];
        m_limit = m_owner ? int'(limit1) : int'(limit0);
        plan.push_back(0);
        for (int i = 0; i < m_limit; i++) plan.push_back(1);
        plan.push_back(2);
        plan.push_back(3);
      end
    end else if (plan[0] != 3 && !req[m_owner]) begin
      plan.delete();
      m_last = m_owner;
    end else begin
      if (plan[0] == 3) m_last = m_owner;
      void'(plan.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int d0;
    @(posedge clk);
    #1;
    plan.delete();
    m_last  = 1'b1;
    m_owner = 1'b0;
    reset   = 1'b0;
    cycle();

    // Single owner, limit 3
    d0 = n_done; done_q.delete();
    limit0 = W'(3); req = 2'b01;
    cycles(6);
    req = 2'b00;
    cycles(3);
    check("single_run_done_count", 32'(n_done - d0), 32'd1);

    // Alternation with both requesting, after a fresh reset
    reset = 1'b1; cycle(); reset = 1'b0;
    d0 = n_done; done_q.delete();
    limit0 = W'(2); limit1 = W'(5); req = 2'b11;
    cycles(20);
    req = 2'b00;
    cycles(3);
    check("rr_done_count", 32'(n_done - d0), 32'd3);
    if (done_q.size() == 3) begin
      check("rr_done_0", 32'(done_q[0]), 32'h1);
      check("rr_done_1", 32'(done_q[1]), 32'h2);
      check("rr_done_2", 32'(done_q[2]), 32'h1);
    end

    // Zero limit
    d0 = n_done;
    limit1 = W'(0); req = 2'b10;
    cycles(3);
    req = 2'b00;
    cycles(2);
    check("zero_limit_done_count", 32'(n_done - d0), 32'd1);

    // Abort of owner 0 with requester 1 pending
    d0 = n_done; done_q.delete();
    limit0 = W'(9); limit1 = W'(1); req = 2'b11;
    cycles(3);
    req = 2'b10;
    cycles(5);
    req = 2'b00;
    cycles(3);
    check("abort_done_count", 32'(n_done - d0), 32'd1);
    if (done_q.size() == 1) check("abort_done_owner", 32'(done_q[0]), 32'h2);

    // Reset in the middle of a run
    d0 = n_done;
    limit0 = W'(15); req = 2'b01;
    cycles(6);
    reset = 1'b1; req = 2'b00;
    cycle();
    reset = 1'b0;
    cycles(3);
    check("reset_midrun_no_done", 32'(n_done - d0), 32'd0);

    // Limit change after grant is ignored
    d0 = n_done;
    limit0 = W'(6); req = 2'b01;
    cycles(4);
    limit0 = W'(1);
    cycles(5);
    req = 2'b00;
    cycles(3);
    check("limit_change_done_count", 32'(n_done - d0), 32'd1);

    // Full-scale limit
    d0 = n_done;
    limit0 = W'(15); req = 2'b01;
    cycles(18);
    req = 2'b00;
    cycles(2);
    check("max_limit_done_count", 32'(n_done - d0), 32'd1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        limit0 = ($urandom_range(0, 9) == 0) ? W'(15) : W'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0)
        limit1 = ($urandom_range(0, 9) == 0) ? W'(15) : W'($urandom_range(0, 6));
      reset = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
